mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default widths for the I/D memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int MAX_WAIT_DEF = 8;
  function automatic int wait_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: I/D tie-break; round-robin when MEM_ARB_RR_EN is defined, else D priority with starvation guard.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WW = wait_w(MAX_WAIT)
) (
  input  logic pend_I,
  input  logic pend_D,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`else
  input  logic [WW-1:0] wait_cnt,
`endif
  output logic grant_I,
  output logic grant_D
);
  logic tie_I;
`ifdef MEM_ARB_RR_EN
  assign tie_I = last == OWN_D;
`else
  assign tie_I = wait_cnt == WW'(MAX_WAIT);
`endif
  always_comb begin
    grant_I = pend_I & (~pend_D | tie_I);
    grant_D = pend_D & ~grant_I;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow line-memory port between I-cache and D-cache, one transaction at a time.
// MEM_ARB_RR_EN selects round-robin tie-break instead of D priority with MAX_WAIT guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [DATA_W-1:0] mem_wdata_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  state_t state;
  logic pend_I, pend_D, grant_I, grant_D, sel_I, take;
  assign pend_I = mem_read_I | mem_write_I;
  assign pend_D = mem_read_D | mem_write_D;
  assign sel_I = state == IDLE ? grant_I : state == BUSY_I;
  assign take = state != IDLE || grant_I || grant_D;
  assign mem_ready_I = ~proc_reset & mem_ready & (state == BUSY_I);
  assign mem_ready_D = ~proc_reset & mem_ready & (state == BUSY_D);
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;
`ifdef MEM_ARB_RR_EN
  logic last;
  always_ff @(posedge clk)
    if (proc_reset) last <= OWN_D;
    else if (state == IDLE && (grant_I || grant_D)) last <= grant_I ? OWN_I : OWN_D;
  mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .pend_I(pend_I), .pend_D(pend_D), .last(last), .grant_I(grant_I), .grant_D(grant_D)
  );
`else
  localparam int WW = wait_w(MAX_WAIT);
  logic [WW-1:0] wait_cnt;
  // Counts D grants that bypassed a waiting I request
  always_ff @(posedge clk)
    if (proc_reset) wait_cnt <= '0;
    else if (state == IDLE)
      wait_cnt <= (grant_I || !pend_I) ? '0 :
                  (grant_D && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
  mem_arb_pick #(.MAX_WAIT(MAX_WAIT), .WW(WW)) u_pick (
    .pend_I(pend_I), .pend_D(pend_D), .wait_cnt(wait_cnt), .grant_I(grant_I), .grant_D(grant_D)
  );
`endif
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (take) begin
        mem_addr <= sel_I ? mem_addr_I : mem_addr_D;
        mem_wdata <= sel_I ? mem_wdata_I : mem_wdata_D;
      end
      if (state == IDLE) begin
        if (grant_I || grant_D) begin
          state <= grant_I ? BUSY_I : BUSY_D;
          mem_write <= sel_I ? mem_write_I : mem_write_D;
          mem_read <= sel_I ? mem_read_I & ~mem_write_I : mem_read_D & ~mem_write_D;
        end
      end else if (mem_ready) begin
        state <= IDLE;
        mem_read <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-configurable memory responder and per-port requesters.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = 28;
  localparam int DW = 128;
  logic clk = 1'b0;
  logic proc_reset;
  logic mem_read_I, mem_write_I, mem_ready_I, mem_read_D, mem_write_D, mem_ready_D;
  logic [AW-1:0] mem_addr_I, mem_addr_D, mem_addr;
  logic [DW-1:0] mem_wdata_I, mem_rdata_I, mem_wdata_D, mem_rdata_D, mem_wdata, mem_rdata;
  logic mem_read, mem_write, mem_ready;
  typedef struct {
    logic own;
    logic rd;
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;
  req_t qI[$], qD[$], exp_q[$];
  int checks = 0, failures = 0, cyc = 0, cnt = 0, lat = 5, last_rdy = -1;
  logic mem_en = 1'b1, bb_chk = 1'b0, i_en = 1'b1, prev_stb = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(3)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] line(input logic [AW-1:0] a);
    return {a, 4'h1, ~a, 4'h2, a ^ 28'h5a5a5a5, 4'h3, a + 28'd1, 4'h4};
  endfunction

  function automatic req_t mk(input logic own, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.own = own; r.rd = rd; r.wr = wr; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic drive_ports();
    if (i_en && qI.size() != 0) begin
      mem_read_I = qI[0].rd; mem_write_I = qI[0].wr; mem_addr_I = qI[0].addr; mem_wdata_I = qI[0].data;
    end else begin
      mem_read_I = 1'b0; mem_write_I = 1'b0;
    end
    if (qD.size() != 0) begin
      mem_read_D = qD[0].rd; mem_write_D = qD[0].wr; mem_addr_D = qD[0].addr; mem_wdata_D = qD[0].data;
    end else begin
      mem_read_D = 1'b0; mem_write_D = 1'b0;
    end
  endtask

  task automatic step();
    req_t e;
    logic stb;
    @(negedge clk);
    cyc++;
    if (mem_en) begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = line(mem_addr);
        end
      end
    end
    #1;
    stb = mem_read | mem_write;
    if (bb_chk && stb && !prev_stb && last_rdy >= 0) check("b2b_gap", cyc - last_rdy, 2);
    prev_stb = stb;
    if (mem_ready) begin
      last_rdy = cyc;
      if (exp_q.size() == 0) check("unexpected_done", {mem_ready_I, mem_ready_D}, 2'b00);
      else begin
        e = exp_q.pop_front();
        check("owner", {mem_ready_I, mem_ready_D}, e.own ? 2'b10 : 2'b01);
        check("addr", mem_addr, e.addr);
        check("strobes", {mem_read, mem_write}, {e.rd & ~e.wr, e.wr});
        check("wdata", mem_wdata, e.data);
        check("rdata_I", mem_rdata_I, line(e.addr));
        check("rdata_D", mem_rdata_D, line(e.addr));
      end
    end else check("idle_ready", {mem_ready_I, mem_ready_D}, 2'b00);
    if (mem_ready_I && qI.size() != 0) qI.delete(0);
    if (mem_ready_D && qD.size() != 0) qD.delete(0);
    drive_ports();
  endtask

  task automatic scen(input int nd, input int ni, input logic [15:0] ord, input int n,
                      input logic [AW-1:0] bd, input logic [AW-1:0] bi);
    req_t dl[$], il[$];
    for (int k = 0; k < nd; k++) dl.push_back(mk(OWN_D, 1'b1, 1'b0, bd + AW'(k), ~line(bd + AW'(k))));
    for (int k = 0; k < ni; k++) il.push_back(mk(OWN_I, 1'b1, 1'b0, bi + AW'(k), ~line(bi + AW'(k))));
    foreach (dl[k]) qD.push_back(dl[k]);
    foreach (il[k]) qI.push_back(il[k]);
    for (int k = 0; k < n; k++) exp_q.push_back(ord[n-1-k] ? il.pop_front() : dl.pop_front());
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete(); qI.delete(); qD.delete();
    drive_ports();
    repeat (2) step();
    last_rdy = -1;
  endtask

  initial begin
    req_t w;
    proc_reset = 1'b1;
    mem_ready = 1'b0; mem_rdata = '0;
    mem_addr_I = '0; mem_wdata_I = '0; mem_addr_D = '0; mem_wdata_D = '0;
    drive_ports();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", {mem_read, mem_write, mem_ready_I, mem_ready_D}, 4'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    proc_reset = 1'b0;
    // single D read, grant latency one cycle
    lat = 5;
    scen(1, 0, 16'b0, 1, 28'h0000010, 28'h0);
    step();
    step();
    check("grant_lat", {mem_read, mem_write}, 2'b10);
    check("grant_addr", mem_addr, 28'h0000010);
    run(40);
    // both pending from IDLE
    lat = 3; bb_chk = 1'b1;
`ifdef MEM_ARB_RR_EN
    scen(1, 1, 16'b10, 2, 28'h0000020, 28'h0000040);
`else
    scen(1, 1, 16'b01, 2, 28'h0000020, 28'h0000040);
`endif
    run(60);
    // continuous D with I pending
    lat = 2;
`ifdef MEM_ARB_RR_EN
    i_en = 1'b0;
    scen(8, 2, 16'b0101000000, 10, 28'h0000100, 28'h0000200);
    step();
    i_en = 1'b1;
`else
    scen(8, 2, 16'b0001000100, 10, 28'h0000100, 28'h0000200);
`endif
    run(300);
    // read+write together is a write
    bb_chk = 1'b0; lat = 4;
    w = mk(OWN_D, 1'b1, 1'b1, 28'h0abcdef, {16{8'ha5}});
    qD.push_back(w);
    exp_q.push_back(w);
    run(40);
    // reset in the middle of an I transaction
    mem_en = 1'b0;
    qI.push_back(mk(OWN_I, 1'b1, 1'b0, 28'h0000050, {8{16'h1234}}));
    step();
    step();
    check("rst_busy", {mem_read, mem_write}, 2'b10);
    step();
    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    qI.delete();
    drive_ports();
    check("abort_ctl", {mem_read, mem_write, mem_ready_I, mem_ready_D}, 4'b0);
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    step();
    step();
    mem_ready = 1'b1;
    mem_rdata = {4{32'hdeadbeef}};
    #1;
    check("late_ready", {mem_ready_I, mem_ready_D}, 2'b00);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("late_ignored", {mem_read, mem_write}, 2'b00);
    cnt = 0; mem_en = 1'b1; lat = 3;
    scen(1, 0, 16'b0, 1, 28'h0000300, 28'h0);
    run(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
